// File: rtl/pipe_skid_ir.sv
// IF/ID pipeline register with a two-entry skid buffer.
// Carries instruction + PC+4 from fetch to decode over valid/ready on both
// sides, keeps in_ready registered, inserts bubbles on flush, substitutes a
// NOP on empty outputs and keeps a saturating decode-stall counter.
module pipe_skid_ir #(
   parameter int unsigned       INST_W      = 32,
   parameter int unsigned       PC_W        = 32,
   parameter logic [INST_W-1:0] NOP_INST    = 32'h0000_0000,
   parameter int unsigned       STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PC_W-1:0]        in_pc4,
   input  logic [INST_W-1:0]      in_inst,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_W-1:0]        out_pc4,
   output logic [INST_W-1:0]      out_inst,
   input  logic                   flush,
   input  logic                   clr_stats,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   // Main entry M drives the outputs; skid entry S catches the one extra
   // instruction that can arrive while decode stalls.
   logic                   m_valid_r;
   logic [PC_W-1:0]        m_pc4_r;
   logic [INST_W-1:0]      m_inst_r;
   logic                   s_valid_r;
   logic [PC_W-1:0]        s_pc4_r;
   logic [INST_W-1:0]      s_inst_r;
   logic [STALL_CNT_W-1:0] stall_cnt_r;

   logic in_ready_s;
   logic in_fire_s;
   logic out_fire_s;
   logic stall_s;

   // Handshake decode: in_ready comes straight from the S valid flop, masked during reset.
   always_comb begin
      in_ready_s = ~s_valid_r & ~reset;
      in_fire_s  = in_valid & in_ready_s;
      out_fire_s = m_valid_r & out_ready;
      stall_s    = m_valid_r & ~out_ready;
   end

   // Storage update: reset, then flush, then M refill / S capture in priority order.
   always_ff @(posedge clock) begin
      if (reset) begin
         m_valid_r <= 1'b0;
         s_valid_r <= 1'b0;
         m_pc4_r   <= {PC_W{1'b0}};
         m_inst_r  <= NOP_INST;
         s_pc4_r   <= {PC_W{1'b0}};
         s_inst_r  <= NOP_INST;
      end else if (flush) begin
         m_valid_r <= 1'b0;
         s_valid_r <= 1'b0;
      end else if (!m_valid_r || out_fire_s) begin
         if (s_valid_r) begin
            m_valid_r <= 1'b1;
            m_pc4_r   <= s_pc4_r;
            m_inst_r  <= s_inst_r;
            s_valid_r <= in_fire_s;
            if (in_fire_s) begin
               s_pc4_r  <= in_pc4;
               s_inst_r <= in_inst;
            end
         end else begin
            m_valid_r <= in_fire_s;
            if (in_fire_s) begin
               m_pc4_r  <= in_pc4;
               m_inst_r <= in_inst;
            end
         end
      end else if (in_fire_s) begin
         s_valid_r <= 1'b1;
         s_pc4_r   <= in_pc4;
         s_inst_r  <= in_inst;
      end
   end

   // Saturating decode-stall counter; clear beats increment, flush leaves it alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if (clr_stats) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   // Output gating: an empty stage shows a NOP with zero PC+4 regardless of stale payload.
   always_comb begin
      in_ready  = in_ready_s;
      out_valid = m_valid_r;
      stall_cnt = stall_cnt_r;
      if (m_valid_r) begin
         out_pc4  = m_pc4_r;
         out_inst = m_inst_r;
      end else begin
         out_pc4  = {PC_W{1'b0}};
         out_inst = NOP_INST;
      end
   end

endmodule

// File: doc/pipe_skid_ir.md
Name: pipe_skid_ir

Overview:
- Parametrised IF/ID pipeline register, next generation of the stall-enable style stage.
- Carries a fetched instruction and its PC+4 from fetch to decode using a valid/ready handshake on both sides.
- A two-entry skid buffer gives full throughput and a registered in_ready.
- Adds flush (bubble insertion on branch/jump), NOP substitution on empty outputs, and a saturating stall counter for performance stats.

Parameters:
- INST_W, 32, instruction width in bits
- PC_W, 32, PC+4 width in bits
- NOP_INST, 32'h0000_0000, value driven on out_inst whenever out_valid=0
- STALL_CNT_W, 16, width of saturating stall counter

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents a valid instruction
- in_ready  out  1  stage can accept; registered (equals !skid_valid), forced 0 while reset=1
- in_pc4  in  PC_W  PC+4 of incoming instruction
- in_inst  in  INST_W  incoming instruction
- out_valid  out  1  decode-side instruction valid
- out_ready  in  1  decode accepts (0 = decode stall)
- out_pc4  out  PC_W  held PC+4; 0 when out_valid=0
- out_inst  out  INST_W  held instruction; NOP_INST when out_valid=0
- flush  in  1  kill all held and incoming instructions this cycle
- clr_stats  in  1  clear stall counter
- stall_cnt  out  STALL_CNT_W  count of cycles with out_valid & !out_ready

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S, each with a valid bit plus a pc4/inst payload.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (synchronous, takes priority over everything):
  - M.valid=0, S.valid=0, stall_cnt=0.
  - Outputs during and after reset: out_valid=0, out_pc4=0, out_inst=NOP_INST.
  - in_ready=0 while reset=1; in_ready=1 on the first cycle after reset deasserts.
- Flush (priority below reset, above all transfers):
  - At the next edge, M.valid=0 and S.valid=0.
  - A same-cycle in_fire is discarded.
  - A same-cycle out_fire counts as consumed by decode.
  - in_ready=1 on the following cycle.
- Normal update, evaluated in priority order each edge:
  - M empty or out_fire:
    - S valid: M <= S, S.valid <= 0. If in_fire also occurs, the input goes into S, so S stays valid.
    - S empty: M <= input when in_fire, else M.valid <= 0.
  - M valid and !out_fire: an in_fire loads S.
- Invariant: S is only valid when M is valid. S can never be overwritten, because in_ready=0 whenever S is valid.
- Latency: 1 cycle from in_fire to out_valid when empty.
- Throughput: 1 instruction/cycle with out_ready held high.
- Ordering: strictly FIFO. No drop and no duplication except under flush.
- Output stability: while out_valid=1 and out_ready=0, out_pc4 and out_inst hold constant.
- Bubble: out_valid=0 forces out_inst=NOP_INST and out_pc4=0 (combinational gating). The internal payload is don't-care.
- in_ready deasserts one cycle after S fills and reasserts the cycle after S drains. Upstream may hold or drop in_valid freely.
- stall_cnt:
  - Increments by 1 each edge where out_valid & !out_ready.
  - Saturates at all-ones.
  - clr_stats wins over increment; reset also clears it.
  - Flush does not clear it.
- Width rules: payloads are stored verbatim with no arithmetic. stall_cnt is unsigned.

Test Plan:
- Reset then stream: reset 2 cycles, then in_inst=0x8C01_0004..0x8C01_0007 (pc4 4,8,12,16) with out_ready=1 -> out_valid rises 1 cycle after first in_fire, one instruction per cycle in order; in_ready stays 1 throughout.
- Decode stall: M holds 0x2000_0001, pc4=0x10; drop out_ready for 3 cycles while fetch offers 0x2000_0002 -> S captures it, in_ready=0 from next cycle, out_inst stays 0x2000_0001, stall_cnt=3; release -> 0x2000_0002 follows the next cycle, in_ready=1 one cycle later.
- Flush with full buffer: M and S valid, assert flush together with in_valid=1 -> next cycle out_valid=0, out_inst=NOP_INST, out_pc4=0, in_ready=1; the flushed-cycle input never appears at the output.
- Reset mid-operation: S full and stall_cnt=5, assert reset one cycle -> in_ready=0 during reset; after reset out_valid=0, stall_cnt=0, in_ready=1.
- Counter saturation/clear: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=15 and holds; clr_stats pulsed together with a stall cycle -> 0.
- Random valid/ready: 10k cycles with random in_valid/out_ready/flush at 5% -> scoreboard shows the output sequence equals the input sequence minus flushed entries, with no duplicates.
